// File: rtl/pmem_arbiter_pkg.sv
// Shared LC-3b types plus the arbiter's port/state encodings.
package pmem_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic {
    ARB_PORT0,
    ARB_PORT1
  } arb_port_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } arb_state_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of both requester ports, the physical-memory port and busy.
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  p0_read;
  logic                  p0_write;
  logic [ADDR_WIDTH-1:0] p0_address;
  logic [LINE_WIDTH-1:0] p0_wdata;
  logic [LINE_WIDTH-1:0] p0_rdata;
  logic                  p0_resp;

  logic                  p1_read;
  logic                  p1_write;
  logic [ADDR_WIDTH-1:0] p1_address;
  logic [LINE_WIDTH-1:0] p1_wdata;
  logic [LINE_WIDTH-1:0] p1_rdata;
  logic                  p1_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  logic                  busy;

  // Arbiter side.
  modport slave (
    input  p0_read, p0_write, p0_address, p0_wdata,
    output p0_rdata, p0_resp,
    input  p1_read, p1_write, p1_address, p1_wdata,
    output p1_rdata, p1_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp,
    output busy
  );

  // Requesters and memory side.
  modport master (
    output p0_read, p0_write, p0_address, p0_wdata,
    input  p0_rdata, p0_resp,
    output p1_read, p1_write, p1_address, p1_wdata,
    input  p1_rdata, p1_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp,
    input  busy
  );
endinterface

// File: rtl/pmem_arbiter_control.sv
// Round-robin grant FSM: IDLE/GRANT0/GRANT1 with a forced IDLE cycle after each response.
module pmem_arbiter_control
  import pmem_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      req0,
  input  logic      req1,
  input  logic      mem_resp,
  output logic      load_latch,
  output arb_port_t load_port,
  output arb_port_t grant,
  output logic      granted
);

  arb_state_t state;
  arb_port_t  last_grant;

  // Winner selection is only evaluated in IDLE; the top latches on this edge.
  always_comb begin
    load_latch = 1'b0;
    load_port  = ARB_PORT0;
    if (state == IDLE) begin
      if (req0 && req1) begin
        load_latch = 1'b1;
        load_port  = (last_grant == ARB_PORT0) ? ARB_PORT1 : ARB_PORT0;
      end else if (req0) begin
        load_latch = 1'b1;
        load_port  = ARB_PORT0;
      end else if (req1) begin
        load_latch = 1'b1;
        load_port  = ARB_PORT1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ARB_PORT1;
      grant      <= ARB_PORT0;
      granted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_latch) begin
            state      <= (load_port == ARB_PORT0) ? GRANT0 : GRANT1;
            grant      <= load_port;
            last_grant <= load_port;
            granted    <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (mem_resp) begin
            state   <= IDLE;
            granted <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          granted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Two-port physical-memory arbiter: latches the winner's request and steers the response back.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic           clk,
  input  logic           reset,
  pmem_arbiter_if.slave  bus
);

  logic                  req0;
  logic                  req1;
  logic                  load_latch;
  arb_port_t             load_port;
  arb_port_t             grant;
  logic                  granted;
  logic                  sel0;
  logic                  sel1;

  logic [ADDR_WIDTH-1:0] address_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  read_q;
  logic                  write_q;

  assign req0 = bus.p0_read | bus.p0_write;
  assign req1 = bus.p1_read | bus.p1_write;

  pmem_arbiter_control u_control (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .mem_resp   (bus.mem_resp),
    .load_latch (load_latch),
    .load_port  (load_port),
    .grant      (grant),
    .granted    (granted)
  );

  // Read+write together is a write, so read is masked by write at latch time.
  always_ff @(posedge clk) begin
    if (reset) begin
      address_q <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
    end else if (load_latch) begin
      if (load_port == ARB_PORT0) begin
        address_q <= bus.p0_address;
        wdata_q   <= bus.p0_wdata;
        write_q   <= bus.p0_write;
        read_q    <= bus.p0_read & ~bus.p0_write;
      end else begin
        address_q <= bus.p1_address;
        wdata_q   <= bus.p1_wdata;
        write_q   <= bus.p1_write;
        read_q    <= bus.p1_read & ~bus.p1_write;
      end
    end
  end

  assign sel0 = granted && (grant == ARB_PORT0);
  assign sel1 = granted && (grant == ARB_PORT1);

  assign bus.mem_read    = granted & read_q;
  assign bus.mem_write   = granted & write_q;
  assign bus.mem_address = address_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.busy        = granted;

  assign bus.p0_resp  = sel0 & bus.mem_resp;
  assign bus.p1_resp  = sel1 & bus.mem_resp;
  assign bus.p0_rdata = sel0 ? bus.mem_rdata : '0;
  assign bus.p1_rdata = sel1 ? bus.mem_rdata : '0;

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Arbitrates two cache-miss requesters onto the single physical-memory port.
- Port 0 is the instruction-cache miss path; port 1 is the data path, i.e. the victim-cache controller's pmem_read/pmem_write outputs.
- Grants one requester at a time using round-robin priority, and latches the winner's address, operation and write line.
- Holds the downstream request stable until the memory responds, then routes the response and read line back to the winner only.

Parameters:
- ADDR_WIDTH, 16, width of the physical address (lc3b_word).
- LINE_WIDTH, 128, width of a cache line (lc3b_line).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_read  in  1  port 0 line-read request.
- p0_write  in  1  port 0 line-write request.
- p0_address  in  ADDR_WIDTH  port 0 line address.
- p0_wdata  in  LINE_WIDTH  port 0 write line.
- p0_rdata  out  LINE_WIDTH  read line returned to port 0.
- p0_resp  out  1  port 0 completion pulse.
- p1_read, p1_write, p1_address, p1_wdata, p1_rdata, p1_resp: same set, for port 1.
- mem_read  out  1  downstream read request.
- mem_write  out  1  downstream write request.
- mem_address  out  ADDR_WIDTH  latched downstream address.
- mem_wdata  out  LINE_WIDTH  latched downstream write line.
- mem_rdata  in  LINE_WIDTH  downstream read line.
- mem_resp  in  1  downstream completion pulse.
- busy  out  1  high while a grant is outstanding.

Behaviour:
- Reset:
  - state=IDLE, last_grant=1 (port 0 wins first tie).
  - Latched address, wdata and op cleared to 0.
  - All outputs 0.
- States:
  - IDLE: no grant.
  - GRANT0: port 0 owns memory.
  - GRANT1: port 1 owns memory.
- Port request: a port requests when its read|write is high.
  - If both read and write are high, the access is treated as a write.
- IDLE transitions:
  - Only one port requesting: go to that port's GRANT state.
  - Both requesting: grant the port not equal to last_grant.
  - On the grant edge, latch that port's address, wdata and op (read/write), and set last_grant.
  - No request: stay in IDLE.
- GRANTn outputs:
  - mem_read or mem_write driven from the latched op.
  - mem_address and mem_wdata driven from the latches, constant for the whole grant.
  - busy=1.
- GRANTn on mem_resp=1:
  - pn_resp=1 combinationally in the same cycle.
  - pn_rdata = mem_rdata. Passthrough is valid whenever granted; it is 0 for the non-granted port.
  - Next state = IDLE.
- GRANTn with mem_resp=0: stay in GRANTn.
- Mandatory IDLE cycle after every response:
  - Lets the requester drop its request; no back-to-back grant.
- Minimum latency: request in cycle N (IDLE) → mem_* asserted in cycle N+1 → response in the same cycle as mem_resp.
- The non-granted port never sees resp, even if it is requesting with an identical address.
- Requester drops or changes its request mid-grant:
  - Ignored; latched values are still driven until mem_resp.
  - The resp pulse is still delivered to that port.
- mem_resp while in IDLE: ignored, no pn_resp.
- Reset mid-grant:
  - Next state IDLE, mem_read/mem_write deasserted in the following cycle, last_grant=1.
  - The in-flight transaction is abandoned; the memory model must tolerate this.
- Fairness: with both ports continuously requesting, grants strictly alternate.
  - Worst-case wait is one foreign transaction plus one IDLE cycle.

Decomposition:
- lc3b_types (shared package):
  - Existing lc3b_word and lc3b_line.
  - Add typedef enum arb_port_t {ARB_PORT0, ARB_PORT1}, used for last_grant and grant.
- Sub-modules:
  - One FSM module, pmem_arbiter_control: IDLE/GRANT0/GRANT1, last_grant, grant, and load_latch outputs.
  - The top level holds the address/wdata/op registers and the response/rdata muxing.
  - No further sub-modules.

Test Plan:
1. Reset, then p0_read with p0_address=16'h1230 → mem_read=1 and mem_address=16'h1230 from the next cycle. Memory responds after 5 cycles with mem_rdata=128'hA5…A5 → p0_resp=1 and p0_rdata=A5…A5 for 1 cycle; p1_resp stays 0.
2. p1_write with p1_address=16'h4440 and p1_wdata=128'hDEAD…BEEF → mem_write=1 with those values. mem_resp → p1_resp pulse, then 1 IDLE cycle.
3. p0_read and p1_write both asserted from reset → port 0 granted first, then port 1 after the IDLE cycle. Held for 4 transactions: grant order 0,1,0,1.
4. Port 1 changes p1_address from 16'h4440 to 16'h5550 mid-grant → mem_address stays 16'h4440 until mem_resp.
5. Reset asserted 2 cycles into a GRANT0 read → mem_read=0 the next cycle. After reset, with both requesting → port 0 granted.
6. mem_resp pulsed while in IDLE → no p0_resp/p1_resp, state stays IDLE. p0_read and p0_write both high → mem_write=1.
